audio_mixer: RTL and testbench

Parametrised multi-channel sound generator and mixer. It replaces fixed-tone, two-source sound logic with NUM_CH independent square-wave tone channels. Each channel is triggered by a one-cycle pulse and has a runtime-programmable half-period and duration. Channel outputs are combined by fixed priority or by OR into one registered `sound` bit that drives the board buzzer pin; game logic (jump, game-over, score milestones) connects one trigger per channel.

---
 rtl/audio_pkg.sv | 8 +
 rtl/tone_channel.sv | 65 ++++++
 rtl/audio_mixer.sv | 83 ++++++++
 tb/tb_audio_mixer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared mixer constants, channel state type and default field widths
package audio_pkg;
    localparam int MIX_PRIORITY = 0;
    localparam int MIX_OR       = 1;
    localparam int PERIOD_W_DEF = 16;
    localparam int DUR_W_DEF    = 24;
    typedef enum logic {CH_IDLE, CH_PLAY} ch_state_e;
endpackage

// File: rtl/tone_channel.sv
// tone_channel: one triggered square-wave tone with latched half-period and duration
module tone_channel
    import audio_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int DUR_W    = DUR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trigger,
    input  logic [PERIOD_W-1:0] half_period,
    input  logic [DUR_W-1:0]    duration,
    output logic                busy,
    output logic                wave
);
    ch_state_e           state_q, state_d;
    logic [PERIOD_W-1:0] hp_q, hp_d, tone_q, tone_d;
    logic [DUR_W-1:0]    rem_q, rem_d;
    logic                wave_q, wave_d;
    logic                start;

    always_comb begin
        start   = trigger && (half_period != '0) && (duration != '0);
        state_d = state_q;
        hp_d    = hp_q;
        tone_d  = tone_q;
        rem_d   = rem_q;
        wave_d  = wave_q;
        if (start) begin
            state_d = CH_PLAY;
            hp_d    = half_period;
            tone_d  = '0;
            rem_d   = duration;
            wave_d  = 1'b1;
        end else if (state_q == CH_PLAY) begin
            tone_d = (tone_q == hp_q - 1'b1) ? '0 : tone_q + 1'b1;
            wave_d = (tone_q == hp_q - 1'b1) ? ~wave_q : wave_q;
            rem_d  = rem_q - 1'b1;
            if (rem_q == DUR_W'(1)) begin
                state_d = CH_IDLE;
                tone_d  = '0;
                wave_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CH_IDLE;
            hp_q    <= '0;
            tone_q  <= '0;
            rem_q   <= '0;
            wave_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            tone_q  <= tone_d;
            rem_q   <= rem_d;
            wave_q  <= wave_d;
        end
    end

    assign busy = (state_q == CH_PLAY);
    assign wave = wave_q;
endmodule

// File: rtl/audio_mixer.sv
// audio_mixer: NUM_CH tone channels mixed by priority or OR into a registered buzzer bit
// Optional AUDIO_MIXER_VOLUME_EN adds a PWM volume gate on the output.
module audio_mixer
    import audio_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int DUR_W    = DUR_W_DEF,
    parameter int MIX_MODE = MIX_PRIORITY,
`ifdef AUDIO_MIXER_VOLUME_EN
    parameter int VOL_W    = 4,
`endif
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [NUM_CH-1:0]          trigger,
    input  logic [NUM_CH*PERIOD_W-1:0] half_period,
    input  logic [NUM_CH*DUR_W-1:0]    duration,
`ifdef AUDIO_MIXER_VOLUME_EN
    input  logic [VOL_W-1:0]           volume,
`endif
    output logic [NUM_CH-1:0]          busy,
    output logic [CH_W-1:0]            active_ch,
    output logic                       sound
);
    logic [NUM_CH-1:0] wave;
    logic              pri_wave, mix, gate;
    logic              sound_q, sound_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tone_channel #(.PERIOD_W(PERIOD_W), .DUR_W(DUR_W)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .trigger    (trigger[i]),
            .half_period(half_period[i*PERIOD_W +: PERIOD_W]),
            .duration   (duration[i*DUR_W +: DUR_W]),
            .busy       (busy[i]),
            .wave       (wave[i])
        );
    end

    // busy/active_ch come straight from channel state flops, so they track busy without extra lag
    always_comb begin
        active_ch = '0;
        pri_wave  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (busy[i]) begin
                active_ch = CH_W'(i);
                pri_wave  = wave[i];
            end
        end
    end

`ifdef AUDIO_MIXER_VOLUME_EN
    logic [VOL_W-1:0] pwm_cnt_q, pwm_cnt_d;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        gate      = (&volume) | (pwm_cnt_q < volume);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_cnt_q <= '0;
        else     pwm_cnt_q <= pwm_cnt_d;
    end
`else
    assign gate = 1'b1;
`endif

    always_comb begin
        mix     = (MIX_MODE == MIX_OR) ? |wave : pri_wave;
        sound_d = enable & mix & gate;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sound_q <= 1'b0;
        else     sound_q <= sound_d;
    end

    assign sound = sound_q;
endmodule

// File: tb/tb_audio_mixer.sv
// tb_audio_mixer: scoreboard bench running priority and OR mixers against a timeline model
module tb_audio_mixer;
    localparam int NCH = 2;
    localparam int PW  = 16;
    localparam int DW  = 24;

    typedef struct packed {
        logic [NCH-1:0] busy;
        logic           act;
        logic           snd0;
        logic           snd1;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [NCH-1:0]    trigger;
    logic [NCH*PW-1:0] half_period;
    logic [NCH*DW-1:0] duration;
    logic [NCH-1:0]    busy0, busy1;
    logic              act0, act1, sound0, sound1;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   k = 0;
    bit   m_act[NCH];
    int   m_st[NCH], m_hp[NCH], m_du[NCH];
    bit   pm0, pm1;

    audio_mixer #(.NUM_CH(NCH), .PERIOD_W(PW), .DUR_W(DW), .MIX_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .trigger(trigger), .half_period(half_period),
        .duration(duration), .busy(busy0), .active_ch(act0), .sound(sound0)
    );

    audio_mixer #(.NUM_CH(NCH), .PERIOD_W(PW), .DUR_W(DW), .MIX_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .trigger(trigger), .half_period(half_period),
        .duration(duration), .busy(busy1), .active_ch(act1), .sound(sound1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("busy_pri", 32'(busy0), 32'(e.busy));
            chk("busy_or", 32'(busy1), 32'(e.busy));
            chk("active_ch_pri", 32'(act0), 32'(e.act));
            chk("active_ch_or", 32'(act1), 32'(e.act));
            chk("sound_pri", 32'(sound0), 32'(e.snd0));
            chk("sound_or", 32'(sound1), 32'(e.snd1));
        end
    end

    // A channel started at edge s is, after edge k, at elapsed e=k-s: playing while e<dur,
    // and high during even-numbered half-periods.
    task automatic model();
        exp_t x;
        int   lo, el;
        bit   b[NCH], w[NCH];
        bit   m0, m1;
        x = '0;
        if (rst) begin
            for (int i = 0; i < NCH; i++) m_act[i] = 1'b0;
            pm0 = 1'b0;
            pm1 = 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (trigger[i] && half_period[i*PW +: PW] != 0 && duration[i*DW +: DW] != 0) begin
                    m_act[i] = 1'b1;
                    m_st[i]  = k;
                    m_hp[i]  = int'(half_period[i*PW +: PW]);
                    m_du[i]  = int'(duration[i*DW +: DW]);
                end
            end
            lo = -1;
            m1 = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                el   = k - m_st[i];
                b[i] = m_act[i] && el < m_du[i];
                w[i] = b[i] && ((el / m_hp[i]) % 2 == 0);
                if (b[i] && lo < 0) lo = i;
                m1 = m1 | w[i];
                x.busy[i] = b[i];
            end
            m0     = (lo >= 0) ? w[lo] : 1'b0;
            x.act  = (lo > 0);
            x.snd0 = enable & pm0;
            x.snd1 = enable & pm1;
            pm0    = m0;
            pm1    = m1;
        end
        exp_q.push_back(x);
    endtask

    task automatic step(input bit mid_rst = 1'b0);
        @(posedge clk);
        k++;
        #1;
        if (mid_rst) begin
            rst = 1'b1;
            #1;
        end
        model();
        trigger = '0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_ch(input int i, input int hp, input int du);
        trigger[i]                = 1'b1;
        half_period[i*PW +: PW]   = PW'(hp);
        duration[i*DW +: DW]      = DW'(du);
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b1;
        trigger     = '0;
        half_period = '0;
        duration    = '0;
        steps(3);
        rst = 1'b0;
        steps(2);
        // single tone
        set_ch(0, 3, 12);
        step();
        steps(16);
        // reset mid-play
        set_ch(0, 3, 20);
        step();
        steps(4);
        step(1'b1);
        steps(2);
        rst = 1'b0;
        steps(5);
        // priority overlap
        set_ch(1, 2, 40);
        step();
        steps(9);
        set_ch(0, 5, 10);
        step();
        steps(35);
        // zero-field triggers on idle channels
        set_ch(0, 3, 0);
        step();
        steps(3);
        set_ch(1, 0, 5);
        step();
        steps(3);
        // both playing, retrigger, zero-field retrigger, enable drop
        set_ch(0, 3, 30);
        set_ch(1, 4, 30);
        step();
        steps(10);
        set_ch(0, 3, 30);
        step();
        steps(3);
        set_ch(1, 0, 9);
        step();
        steps(2);
        enable = 1'b0;
        steps(4);
        enable = 1'b1;
        steps(25);
        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(11, 0) == 0)
                    set_ch(i, int'($urandom_range(6, 0)), int'($urandom_range(50, 0)));
            enable = ($urandom_range(9, 0) != 0);
            if (rst) rst = 1'b0;
            step($urandom_range(399, 0) == 0);
        end
        rst = 1'b0;
        steps(3);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
